// File: rtl/shift_reg_ctrl_if.sv
// Handshake and shift-register bus for shift_reg_ctrl.
//   in_valid_i/in_ready_o/in_data_i  : upstream valid/ready stream
//   flush_i                          : single-cycle drain request
//   out_valid_o/out_ready_i/out_data_o : downstream valid/ready stream
//   sr_we_o/sr_data_o/sr_data_i      : external shift register shift enable, stage-0 input, last-stage tap
//   busy_o/count_o                   : drain in progress, number of held words
// The slave modport is the controller's view; master is the environment's view.
interface shift_reg_ctrl_if #(
  parameter int unsigned Width = 8,
  parameter int unsigned Size  = 4
);
  localparam int unsigned CntW = $clog2(Size + 1);

  logic             in_valid_i;
  logic             in_ready_o;
  logic [Width-1:0] in_data_i;
  logic             flush_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [Width-1:0] out_data_o;
  logic             sr_we_o;
  logic [Width-1:0] sr_data_o;
  logic [Width-1:0] sr_data_i;
  logic             busy_o;
  logic [CntW-1:0]  count_o;

  modport slave (
    input  in_valid_i, in_data_i, flush_i, out_ready_i, sr_data_i,
    output in_ready_o, out_valid_o, out_data_o, sr_we_o, sr_data_o, busy_o, count_o
  );

  modport master (
    output in_valid_i, in_data_i, flush_i, out_ready_i, sr_data_i,
    input  in_ready_o, out_valid_o, out_data_o, sr_we_o, sr_data_o, busy_o, count_o
  );
endinterface

// File: rtl/shift_reg_ctrl.sv
// Flow-control sequencer turning a Width x Size write-enable delay line into a
// valid/ready stream stage. A per-stage valid shadow tracks which stages hold
// real words; a flush pushes zero bubbles until every held word is delivered.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset
//   bus   : shift_reg_ctrl_if.slave (stream, flush, shift register, status)
module shift_reg_ctrl #(
  parameter int unsigned Width = 8,
  parameter int unsigned Size  = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  shift_reg_ctrl_if.slave    bus
);

  localparam int unsigned CntW = $clog2(Size + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [Size-1:0]  vld_q, vld_d;

  logic             room;
  logic             in_ready;
  logic             push;
  logic             pop;
  logic             sr_we;
  logic [Width-1:0] sr_data;
  logic [CntW-1:0]  cnt;

  // Handshake terms and next shadow/state
  always_comb begin
    room     = ~vld_q[Size-1] | bus.out_ready_i;
    in_ready = (state_q != DRAIN) & room;
    // Reset also suppresses the shift so the register sees no stray enable
    push     = bus.in_valid_i & in_ready & ~rst_i;
    pop      = vld_q[Size-1] & bus.out_ready_i;

    sr_we    = 1'b0;
    sr_data  = '0;
    vld_d    = vld_q;
    state_d  = state_q;

    if (state_q == DRAIN) begin
      // Bubble shift; a word at the top leaves with it (room implies ready)
      sr_we = room & (|vld_q);
      if (sr_we) vld_d = {vld_q[Size-2:0], 1'b0};
    end else begin
      sr_we = push;
      if (push) begin
        sr_data = bus.in_data_i;
        vld_d   = {vld_q[Size-2:0], 1'b1};
      end else if (pop) begin
        // Word stays in the register but is no longer live
        vld_d[Size-1] = 1'b0;
      end
    end

    unique case (state_q)
      IDLE:    if (push) state_d = RUN;
      RUN: begin
        if (bus.flush_i)      state_d = DRAIN;
        else if (vld_d == '0) state_d = IDLE;
      end
      DRAIN:   if (vld_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Population count of the valid shadow
  always_comb begin
    cnt = '0;
    for (int k = 0; k < int'(Size); k++) begin
      cnt = cnt + CntW'(vld_q[k]);
    end
  end

  // State and shadow registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = vld_q[Size-1];
  assign bus.out_data_o  = bus.sr_data_i;
  assign bus.sr_we_o     = sr_we;
  assign bus.sr_data_o   = sr_data;
  assign bus.busy_o      = (state_q == DRAIN);
  assign bus.count_o     = cnt;

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Bench for shift_reg_ctrl (Width=8, Size=3) with a behavioural shift register
// attached to the sr_* taps, a vector table, hand-written reset sequences and a
// randomized run against an age-based queue model.
module tb_shift_reg_ctrl;

  localparam int unsigned W = 8;
  localparam int unsigned S = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shift_reg_ctrl_if #(.Width(W), .Size(S)) bus ();

  shift_reg_ctrl #(.Width(W), .Size(S)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // External delay line driven by the controller
  logic [W-1:0] sr_q [S];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(S); i++) sr_q[i] <= '0;
    end else if (bus.sr_we_o) begin
      sr_q[0] <= bus.sr_data_o;
      for (int i = 1; i < int'(S); i++) sr_q[i] <= sr_q[i-1];
    end
  end
  assign bus.sr_data_i = sr_q[S-1];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
    @(negedge clk);
    bus.in_valid_i  = iv;
    bus.in_data_i   = d;
    bus.out_ready_i = ordy;
    bus.flush_i     = fl;
    #1;
  endtask

  typedef struct {
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         fl;
    logic         e_rdy;
    logic         e_ov;
    int           e_cnt;
    logic [W-1:0] e_od;
    logic         e_busy;
    logic         e_we;
    logic [W-1:0] e_srd;
  } vec_t;

  function automatic vec_t v(logic iv, logic [W-1:0] d, logic ordy, logic fl,
                             logic rdy, logic ov, int cnt, logic [W-1:0] od,
                             logic busy, logic we, logic [W-1:0] srd);
    vec_t r;
    r.iv = iv; r.d = d; r.ordy = ordy; r.fl = fl;
    r.e_rdy = rdy; r.e_ov = ov; r.e_cnt = cnt; r.e_od = od;
    r.e_busy = busy; r.e_we = we; r.e_srd = srd;
    return r;
  endfunction

  // Reference model: live words with the number of shifts each has seen
  typedef struct {
    logic [W-1:0] d;
    int           age;
  } ent_t;
  ent_t q[$];
  int   mode;  // 0 idle, 1 run, 2 drain

  localparam int NV = 29;
  vec_t tbl [NV];

  initial begin
    logic         top, room, rdy, push, pop, we;
    logic [W-1:0] srd;
    logic         iv, ordy, fl;
    logic [W-1:0] d;

    bus.in_valid_i  = 1'b0;
    bus.in_data_i   = '0;
    bus.out_ready_i = 1'b0;
    bus.flush_i     = 1'b0;

    // Table: reset state assumed, pre-edge expectations per cycle
    tbl[0]  = v(1, 8'h10, 0, 0,  1, 0, 0, 8'h00, 0, 1, 8'h10);
    tbl[1]  = v(1, 8'h21, 0, 0,  1, 0, 1, 8'h00, 0, 1, 8'h21);
    tbl[2]  = v(1, 8'h32, 0, 0,  1, 0, 2, 8'h00, 0, 1, 8'h32);
    tbl[3]  = v(0, 8'h00, 0, 0,  0, 1, 3, 8'h10, 0, 0, 8'h00);
    tbl[4]  = v(1, 8'h43, 1, 0,  1, 1, 3, 8'h10, 0, 1, 8'h43);
    for (int i = 5; i < 10; i++)
      tbl[i] = v(1, 8'hee, 0, 0, 0, 1, 3, 8'h21, 0, 0, 8'h00);
    tbl[10] = v(0, 8'h00, 1, 0,  1, 1, 3, 8'h21, 0, 0, 8'h00);
    tbl[11] = v(0, 8'h00, 0, 1,  1, 0, 2, 8'h00, 0, 0, 8'h00);
    tbl[12] = v(0, 8'h00, 0, 0,  0, 0, 2, 8'h00, 1, 1, 8'h00);
    tbl[13] = v(0, 8'h00, 0, 0,  0, 1, 2, 8'h32, 1, 0, 8'h00);
    tbl[14] = v(0, 8'h00, 1, 0,  0, 1, 2, 8'h32, 1, 1, 8'h00);
    tbl[15] = v(0, 8'h00, 1, 0,  0, 1, 1, 8'h43, 1, 1, 8'h00);
    tbl[16] = v(0, 8'h00, 0, 0,  1, 0, 0, 8'h00, 0, 0, 8'h00);
    tbl[17] = v(1, 8'h5a, 1, 0,  1, 0, 0, 8'h00, 0, 1, 8'h5a);
    tbl[18] = v(0, 8'h00, 1, 1,  1, 0, 1, 8'h00, 0, 0, 8'h00);
    tbl[19] = v(0, 8'h00, 1, 0,  0, 0, 1, 8'h00, 1, 1, 8'h00);
    tbl[20] = v(0, 8'h00, 1, 0,  0, 0, 1, 8'h00, 1, 1, 8'h00);
    tbl[21] = v(0, 8'h00, 1, 0,  0, 1, 1, 8'h5a, 1, 1, 8'h00);
    tbl[22] = v(0, 8'h00, 1, 0,  1, 0, 0, 8'h00, 0, 0, 8'h00);
    tbl[23] = v(1, 8'h11, 1, 0,  1, 0, 0, 8'h00, 0, 1, 8'h11);
    tbl[24] = v(1, 8'h77, 1, 1,  1, 0, 1, 8'h00, 0, 1, 8'h77);
    tbl[25] = v(0, 8'h00, 1, 0,  0, 0, 2, 8'h00, 1, 1, 8'h00);
    tbl[26] = v(0, 8'h00, 1, 0,  0, 1, 2, 8'h11, 1, 1, 8'h00);
    tbl[27] = v(0, 8'h00, 1, 0,  0, 1, 1, 8'h77, 1, 1, 8'h00);
    tbl[28] = v(0, 8'h00, 1, 0,  1, 0, 0, 8'h00, 0, 0, 8'h00);

    // Power-on reset
    repeat (2) @(negedge clk);
    chk("por_out_valid", 32'(bus.out_valid_o), 0);
    chk("por_in_ready",  32'(bus.in_ready_o), 1);
    chk("por_count",     32'(bus.count_o), 0);
    rst = 1'b0;

    // Asynchronous reset mid-cycle with words held
    drive(1, 8'haa, 0, 0);
    drive(1, 8'hbb, 0, 0);
    drive(0, 8'h00, 0, 0);
    chk("pre_rst_count", 32'(bus.count_o), 2);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid_o), 0);
    chk("arst_in_ready",  32'(bus.in_ready_o), 1);
    chk("arst_count",     32'(bus.count_o), 0);
    chk("arst_sr_we",     32'(bus.sr_we_o), 0);
    chk("arst_busy",      32'(bus.busy_o), 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl);
      chk($sformatf("v%0d_in_ready", i),  32'(bus.in_ready_o),  32'(tbl[i].e_rdy));
      chk($sformatf("v%0d_out_valid", i), 32'(bus.out_valid_o), 32'(tbl[i].e_ov));
      chk($sformatf("v%0d_count", i),     32'(bus.count_o),     32'(tbl[i].e_cnt));
      chk($sformatf("v%0d_busy", i),      32'(bus.busy_o),      32'(tbl[i].e_busy));
      chk($sformatf("v%0d_sr_we", i),     32'(bus.sr_we_o),     32'(tbl[i].e_we));
      chk($sformatf("v%0d_sr_data", i),   32'(bus.sr_data_o),   32'(tbl[i].e_srd));
      if (tbl[i].e_ov)
        chk($sformatf("v%0d_out_data", i), 32'(bus.out_data_o), 32'(tbl[i].e_od));
    end

    // Reset while draining aborts the drain
    drive(1, 8'hc1, 0, 0);
    drive(1, 8'hc2, 0, 0);
    drive(0, 8'h00, 0, 1);
    drive(0, 8'h00, 0, 0);
    chk("drain_busy", 32'(bus.busy_o), 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("drain_rst_busy",  32'(bus.busy_o), 0);
    chk("drain_rst_count", 32'(bus.count_o), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(0, 8'h00, 1, 0);
      chk($sformatf("post_rst%0d_out_valid", i), 32'(bus.out_valid_o), 0);
      chk($sformatf("post_rst%0d_count", i),     32'(bus.count_o), 0);
      chk($sformatf("post_rst%0d_busy", i),      32'(bus.busy_o), 0);
    end

    // Randomized run against the queue model (DUT is idle and empty here)
    q.delete();
    mode = 0;
    for (int c = 0; c < 3000; c++) begin
      iv   = ($urandom_range(0, 9) < 6);
      ordy = ($urandom_range(0, 9) < 5);
      fl   = ($urandom_range(0, 19) == 0);
      d    = W'($urandom);
      drive(iv, d, ordy, fl);

      top  = (q.size() > 0) && (q[0].age == int'(S));
      room = !top || ordy;
      rdy  = (mode != 2) && room;
      push = iv && rdy;
      pop  = top && ordy;
      we   = (mode == 2) ? (room && q.size() > 0) : push;
      srd  = (mode != 2 && push) ? d : '0;

      chk("rnd_in_ready",  32'(bus.in_ready_o), 32'(rdy));
      chk("rnd_out_valid", 32'(bus.out_valid_o), 32'(top));
      chk("rnd_count",     32'(bus.count_o), 32'(q.size()));
      chk("rnd_busy",      32'(bus.busy_o), 32'(mode == 2));
      chk("rnd_sr_we",     32'(bus.sr_we_o), 32'(we));
      chk("rnd_sr_data",   32'(bus.sr_data_o), 32'(srd));
      if (top) chk("rnd_out_data", 32'(bus.out_data_o), 32'(q[0].d));

      if (we) begin
        foreach (q[k]) q[k].age++;
        if (q.size() > 0 && q[0].age > int'(S)) void'(q.pop_front());
        if (mode != 2 && push) q.push_back('{d: d, age: 1});
      end else if (pop) begin
        void'(q.pop_front());
      end

      case (mode)
        0: if (push) mode = 1;
        1: if (fl) mode = 2; else if (q.size() == 0) mode = 0;
        default: if (q.size() == 0) mode = 0;
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_reg_ctrl.md
Name: shift_reg_ctrl

Overview:
Flow-control sequencer for a Width x Size delay-line shift register instance. It converts the raw write-enable shifter into a valid/ready stream stage, tracking which stages hold real data in a per-stage valid shadow. It also supports a flush that pushes bubbles until all held words have been delivered. It sits between an upstream producer, a downstream consumer and one external shift register whose data_o tap is fed back to it.

Parameters:
Width, 8, data word width in bits.
Size, 4, number of stages in the controlled shift register; legal range 2..64.

Ports:
clk_i  input  1  clock; all state updates on the rising edge.
rst_i  input  1  asynchronous, active-high reset.
in_valid_i  input  1  upstream word present.
in_ready_o  output  1  controller accepts in_data_i this cycle.
in_data_i  input  Width  upstream word.
flush_i  input  1  single-cycle request to drain all held words.
out_valid_o  output  1  out_data_o holds a real word.
out_ready_i  input  1  downstream consumes out_data_o this cycle.
out_data_o  output  Width  equals sr_data_i (combinational pass-through).
sr_we_o  output  1  shift enable to the shift register's we input.
sr_data_o  output  Width  word shifted into stage 0.
sr_data_i  input  Width  last-stage tap from the shift register.
busy_o  output  1  high in DRAIN.
count_o  output  $clog2(Size+1)  number of set valid-shadow bits.

Behaviour:
- State: vld[Size-1:0] shadow (bit k = stage k holds data) and FSM {IDLE, RUN, DRAIN}.
- Reset (async, rst_i=1): vld=0, state IDLE.
  - Outputs during and after reset: out_valid_o=0, in_ready_o=1, sr_we_o=0, busy_o=0, count_o=0.
  - The shift register's own reset is tied to the same source. Its stage contents are don't-care because vld=0.
- out_valid_o = vld[Size-1].
- room = ~vld[Size-1] | out_ready_i.
- in_ready_o = (state != DRAIN) & room. This is combinational and does not depend on in_valid_i or flush_i.
- push = in_valid_i & in_ready_o.
- pop = out_valid_o & out_ready_i.
- IDLE/RUN shifting:
  - sr_we_o = push.
  - sr_data_o = in_data_i when push, else 0.
  - On a shift: vld <= {vld[Size-2:0], 1'b1}.
  - On pop without push: vld[Size-1] <= 0, other bits hold. The word stays physically in the register and is overwritten later.
- DRAIN shifting:
  - sr_we_o = room & (|vld).
  - sr_data_o = 0 (bubble).
  - On a shift: vld <= {vld[Size-2:0], 1'b0}. A word at the top is popped by the same shift when out_ready_i=1.
  - Pop without shift is impossible in DRAIN.
- Latency: a pushed word reaches out_data_o after Size shifts (further pushes or drain bubbles), never on its own. Zero bubbles exist between held words, except gaps created by pops without push.
- FSM transitions:
  - IDLE -> RUN on push.
  - RUN -> DRAIN on flush_i. If push occurs in the same cycle, the push is accepted first, then DRAIN.
  - RUN -> IDLE when the next vld == 0 and flush_i=0.
  - DRAIN -> IDLE when the next vld == 0.
  - flush_i is ignored in IDLE and DRAIN.
- Boundaries:
  - Full (vld[Size-1]=1) with out_ready_i=0: in_ready_o=0, sr_we_o=0, all state holds.
  - Full with out_ready_i=1 and in_valid_i=1: push and pop in the same cycle; count_o unchanged.
  - count_o saturates naturally at Size; it is never above Size or below 0.
- Reset mid-DRAIN aborts immediately to IDLE with vld=0.
- No combinational path from out_ready_i to out_valid_o.

Test Plan:
(Width=8, Size=3.)
1. Reset: assert rst_i asynchronously mid-cycle -> outputs go immediately to out_valid_o=0, in_ready_o=1, count_o=0, sr_we_o=0, busy_o=0.
2. Push A0, A1, A2 on consecutive cycles with out_ready_i=0 -> count_o 1,2,3; out_valid_o=1 and out_data_o=A0 after the third edge; in_ready_o=0. Then push A3 with out_ready_i=1 -> A0 popped and A3 accepted in one cycle; out_data_o=A1; count_o stays 3.
3. Full with out_ready_i=0 held 5 cycles -> sr_we_o=0 throughout; count_o=3; out_data_o stays A1.
4. From full, out_ready_i=1 and in_valid_i=0 for one cycle -> out_valid_o=0, count_o=2, no sr_we_o pulse. Then flush_i -> busy_o=1, in_ready_o=0; bubble shifts emit A2 then A3 as out_valid_o pulses; IDLE follows with count_o=0.
5. Single word 8'h5a pushed then flush_i with out_ready_i=1 -> exactly two bubble shifts, then 8'h5a valid and consumed on the third shift; IDLE the cycle after.
6. flush_i coincident with push of 8'h77 in RUN -> 8'h77 is accepted and delivered during DRAIN. Second scenario: rst_i pulse in DRAIN -> IDLE, vld=0, no further out_valid_o.
